// File: rtl/fa_serial_sequencer.sv
// fa_serial_sequencer: bit-serial add sequencer driving an external 1-bit full adder
// Ports: clk/rst (sync, active-high); start/a/b/cin load a new addition in IDLE;
// fa_i0/fa_i1/fa_ci drive the cell, fa_s/fa_co return from it;
// busy marks RUN, done pulses one cycle when sum/cout are final.
module fa_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                cnt_d   = '0;
                sum_d   = '0;
                cout_d  = 1'b0;
            end
            RUN: begin
                // Sum bits enter at the MSB so the LSB-first stream ends right-aligned.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign fa_i0 = busy & a_q[0];
    assign fa_i1 = busy & b_q[0];
    assign fa_ci = busy & carry_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
endmodule
